// File: rtl/bram_resp_port_if.sv
// Bus bundle for bram_resp_port.
//  Accelerator side : R_req, addr, R_data, W_req, W_data
//  Host side        : host_re, host_we, host_addr, host_wdata, host_rdata, host_rvalid
//  master = requester (accelerator / host driver), slave = the memory.
interface bram_resp_port_if #(
   parameter int AW = 10
);
   logic          R_req;
   logic [31:0]   addr;
   logic [31:0]   R_data;
   logic [3:0]    W_req;
   logic [31:0]   W_data;

   logic          host_re;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [31:0]   host_wdata;
   logic [31:0]   host_rdata;
   logic          host_rvalid;

   modport master (
      output R_req, addr, W_req, W_data,
      input  R_data,
      output host_re, host_we, host_addr, host_wdata,
      input  host_rdata, host_rvalid
   );

   modport slave (
      input  R_req, addr, W_req, W_data,
      output R_data,
      input  host_re, host_we, host_addr, host_wdata,
      output host_rdata, host_rvalid
   );
endinterface

// File: rtl/bram_resp_port.sv
// bram_resp_port: single-port 32-bit word memory shared between an accelerator
// initiator port and a host preload/readback port, with a sequential clear engine.
// Ownership FSM: IDLE (host owns), CLEAR (zeroing, one word per cycle), ACCEL
// (accelerator owns).
// Ports:
//  clk, rst    : clock, synchronous active-high reset
//  bus (slave) : accel R_req/addr/R_data/W_req/W_data, host re/we/addr/wdata/rdata/rvalid
//  acc_start   : pulse, IDLE -> ACCEL
//  acc_finish  : pulse, ACCEL -> IDLE
//  clr         : pulse, IDLE -> CLEAR (wins over acc_start)
//  busy        : state != IDLE, registered
//  oor_err     : sticky, accel access above DEPTH; cleared by rst or entering CLEAR
module bram_resp_port #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             rst,
   bram_resp_port_if.slave  bus,
   input  logic             acc_start,
   input  logic             acc_finish,
   input  logic             clr,
   output logic             busy,
   output logic             oor_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_ACCEL = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_next;
   logic [AW-1:0] r_cnt;
   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rdata;
   logic [31:0]   r_hrdata;
   logic          r_hrvalid;
   logic          r_busy;
   logic          r_oor;

   logic [AW-1:0] w_aidx;
   logic          w_oor;
   logic          w_acc_any;
   logic          w_clr_last;
   logic          w_in_idle;
   logic          w_in_accel;

   assign w_aidx     = bus.addr[AW+1:2];
   assign w_oor      = |bus.addr[31:AW+2];
   assign w_acc_any  = bus.R_req | (|bus.W_req);
   assign w_clr_last = (r_cnt == AW'(DEPTH-1));
   assign w_in_idle  = (r_state == S_IDLE);
   assign w_in_accel = (r_state == S_ACCEL);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (clr)            w_next = S_CLEAR;
            else if (acc_start) w_next = S_ACCEL;
         end
         S_CLEAR: if (w_clr_last) w_next = S_IDLE;
         S_ACCEL: if (acc_finish) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_hrdata  <= '0;
         r_hrvalid <= 1'b0;
         r_busy    <= 1'b0;
         r_oor     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);

         if (r_state == S_CLEAR)
            r_cnt <= w_clr_last ? '0 : r_cnt + 1'b1;

         if (w_in_idle && (w_next == S_CLEAR))
            r_oor <= 1'b0;
         else if (w_in_accel && w_acc_any && w_oor)
            r_oor <= 1'b1;

         // Out-of-range reads return zero rather than an aliased word.
         if (w_in_accel && bus.R_req)
            r_rdata <= w_oor ? 32'd0 : r_mem[w_aidx];

         r_hrvalid <= w_in_idle && bus.host_re;
         if (w_in_idle && bus.host_re)
            r_hrdata <= r_mem[bus.host_addr];
      end
   end

   // Memory array: not reset. Writes are suppressed while rst is high so a
   // reset landing mid-CLEAR leaves the remaining words untouched. Reads above
   // see the pre-edge contents, giving read-first behaviour on collisions.
   always_ff @(posedge clk) begin
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (bus.host_we)
                  r_mem[bus.host_addr] <= bus.host_wdata;
            end
            S_CLEAR: r_mem[r_cnt] <= 32'd0;
            S_ACCEL: begin
               if (!w_oor) begin
                  for (int b = 0; b < 4; b++)
                     if (bus.W_req[b])
                        r_mem[w_aidx][8*b +: 8] <= bus.W_data[8*b +: 8];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.R_data      = r_rdata;
   assign bus.host_rdata  = r_hrdata;
   assign bus.host_rvalid = r_hrvalid;
   assign busy            = r_busy;
   assign oor_err         = r_oor;

endmodule

// File: tb/tb_bram_resp_port.sv
// Self-checking bench for bram_resp_port: directed table, clear/reset
// sequences, then randomized traffic against a behavioural model.
module tb_bram_resp_port;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   typedef struct {
      logic          rst, clr, st, fin, hre, hwe;
      logic [AW-1:0] ha;
      logic [31:0]   hwd;
      logic          rreq;
      logic [31:0]   addr;
      logic [3:0]    wreq;
      logic [31:0]   wd;
   } in_t;

   typedef struct {
      in_t         i;
      logic [31:0] eR;
      logic [31:0] eH;
      logic        eV;
      logic        eB;
      logic        eO;
   } vec_t;

   logic clk;
   logic rst, acc_start, acc_finish, clr, busy, oor_err;

   bram_resp_port_if #(.AW(AW)) bus ();

   bram_resp_port #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .acc_start  (acc_start),
      .acc_finish (acc_finish),
      .clr        (clr),
      .busy       (busy),
      .oor_err    (oor_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Behavioural model: mode 0 = host owns, 1 = clearing, 2 = accel owns.
   logic [31:0] m_mem [DEPTH];
   int          m_mode = 0;
   int          m_ci   = 0;
   logic [31:0] m_R = '0, m_H = '0;
   logic        m_V = 1'b0, m_O = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic in_t nop();
      in_t v;
      v.rst = 0; v.clr = 0; v.st = 0; v.fin = 0; v.hre = 0; v.hwe = 0;
      v.ha = '0; v.hwd = '0; v.rreq = 0; v.addr = '0; v.wreq = '0; v.wd = '0;
      return v;
   endfunction

   function automatic in_t mi(input logic c, input logic s, input logic f,
                              input logic hre, input logic hwe, input int ha,
                              input logic [31:0] hwd, input logic rreq,
                              input logic [31:0] addr, input logic [3:0] wreq,
                              input logic [31:0] wd);
      in_t v = nop();
      v.clr = c; v.st = s; v.fin = f; v.hre = hre; v.hwe = hwe; v.ha = AW'(ha);
      v.hwd = hwd; v.rreq = rreq; v.addr = addr; v.wreq = wreq; v.wd = wd;
      return v;
   endfunction

   task automatic model(input in_t v);
      if (v.rst) begin
         m_mode = 0; m_ci = 0; m_R = '0; m_H = '0; m_V = 0; m_O = 0;
      end else begin
         case (m_mode)
            0: begin
               m_V = v.hre;
               if (v.hre) m_H = m_mem[v.ha];
               if (v.hwe) m_mem[v.ha] = v.hwd;
               if (v.clr) begin m_mode = 1; m_ci = 0; m_O = 0; end
               else if (v.st) m_mode = 2;
            end
            1: begin
               m_V = 0;
               m_mem[m_ci] = '0;
               m_ci++;
               if (m_ci == DEPTH) begin m_mode = 0; m_ci = 0; end
            end
            default: begin
               logic inr;
               int   w;
               m_V = 0;
               inr = (v.addr < 32'(DEPTH*4));
               w   = int'(v.addr >> 2);
               if (v.rreq) begin
                  if (inr) m_R = m_mem[w];
                  else     m_R = '0;
               end
               if (inr) begin
                  for (int b = 0; b < 4; b++)
                     if (v.wreq[b]) m_mem[w][8*b +: 8] = v.wd[8*b +: 8];
               end else if (v.rreq || (v.wreq != 0)) begin
                  m_O = 1;
               end
               if (v.fin) m_mode = 0;
            end
         endcase
      end
   endtask

   task automatic step(input in_t v);
      rst            = v.rst;
      clr            = v.clr;
      acc_start      = v.st;
      acc_finish     = v.fin;
      bus.host_re    = v.hre;
      bus.host_we    = v.hwe;
      bus.host_addr  = v.ha;
      bus.host_wdata = v.hwd;
      bus.R_req      = v.rreq;
      bus.addr       = v.addr;
      bus.W_req      = v.wreq;
      bus.W_data     = v.wd;
      model(v);
      @(posedge clk);
      #1;
   endtask

   task automatic hw(input int a, input logic [31:0] d);
      step(mi(0, 0, 0, 0, 1, a, d, 0, 0, 0, 0));
   endtask

   task automatic hr(input string name, input int a, input logic [31:0] exp);
      step(mi(0, 0, 0, 1, 0, a, 0, 0, 0, 0, 0));
      chk({name, "_rdata"}, bus.host_rdata, exp);
      chk({name, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
   endtask

   vec_t tbl [17];

   initial begin
      in_t v;
      int  cnt;

      // Directed: host preload/readback, byte writes, collisions, out of range.
      tbl[0]  = '{mi(0,0,0,0,1,5,32'hA1B2C3D4,0,0,0,0),             32'h0,        32'h0,        0, 0, 0};
      tbl[1]  = '{mi(0,0,0,1,0,5,0,0,0,0,0),                          32'h0,        32'hA1B2C3D4, 1, 0, 0};
      tbl[2]  = '{nop(),                                              32'h0,        32'hA1B2C3D4, 0, 0, 0};
      tbl[3]  = '{mi(0,1,0,0,0,0,0,0,0,0,0),                          32'h0,        32'hA1B2C3D4, 0, 1, 0};
      tbl[4]  = '{mi(0,0,0,0,0,0,0,0,32'h14,4'b0101,32'h11223344),    32'h0,        32'hA1B2C3D4, 0, 1, 0};
      tbl[5]  = '{mi(0,0,0,0,0,0,0,1,32'h14,0,0),                     32'hA122C344, 32'hA1B2C3D4, 0, 1, 0};
      tbl[6]  = '{mi(0,0,0,1,1,5,32'hFFFFFFFF,0,0,0,0),               32'hA122C344, 32'hA1B2C3D4, 0, 1, 0};
      tbl[7]  = '{mi(0,0,0,0,0,0,0,0,32'h8,4'hF,32'h0),               32'hA122C344, 32'hA1B2C3D4, 0, 1, 0};
      tbl[8]  = '{mi(0,0,0,0,0,0,0,0,32'h0,4'hF,32'h55AA55AA),        32'hA122C344, 32'hA1B2C3D4, 0, 1, 0};
      tbl[9]  = '{mi(0,0,0,0,0,0,0,1,32'h8,4'hF,32'hCAFEBABE),        32'h0,        32'hA1B2C3D4, 0, 1, 0};
      tbl[10] = '{mi(0,0,0,0,0,0,0,1,32'h8,0,0),                      32'hCAFEBABE, 32'hA1B2C3D4, 0, 1, 0};
      tbl[11] = '{mi(0,0,0,0,0,0,0,1,32'h1000,4'hF,32'hDEADBEEF),     32'h0,        32'hA1B2C3D4, 0, 1, 1};
      tbl[12] = '{mi(0,0,0,0,0,0,0,1,32'h0,0,0),                      32'h55AA55AA, 32'hA1B2C3D4, 0, 1, 1};
      tbl[13] = '{mi(0,0,1,0,0,0,0,0,0,0,0),                          32'h55AA55AA, 32'hA1B2C3D4, 0, 0, 1};
      tbl[14] = '{mi(0,0,0,1,0,5,0,0,0,0,0),                          32'h55AA55AA, 32'hA122C344, 1, 0, 1};
      tbl[15] = '{mi(0,0,0,0,0,0,0,1,32'h0,4'hF,32'h0),               32'h55AA55AA, 32'hA122C344, 0, 0, 1};
      tbl[16] = '{mi(0,0,0,1,0,0,0,0,0,0,0),                          32'h55AA55AA, 32'h55AA55AA, 1, 0, 1};

      // Reset state.
      v = nop(); v.rst = 1;
      step(v);
      step(v);
      chk("rst_R_data", bus.R_data, 32'h0);
      chk("rst_host_rdata", bus.host_rdata, 32'h0);
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_oor_err", 32'(oor_err), 32'd0);

      for (int k = 0; k < 17; k++) begin
         step(tbl[k].i);
         chk($sformatf("tbl%0d_R_data", k), bus.R_data, tbl[k].eR);
         chk($sformatf("tbl%0d_host_rdata", k), bus.host_rdata, tbl[k].eH);
         chk($sformatf("tbl%0d_host_rvalid", k), 32'(bus.host_rvalid), 32'(tbl[k].eV));
         chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].eB));
         chk($sformatf("tbl%0d_oor_err", k), 32'(oor_err), 32'(tbl[k].eO));
      end

      // Full clear: busy for exactly DEPTH cycles, host reads dropped, oor cleared.
      step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("clr_oor_cleared", 32'(oor_err), 32'd0);
      cnt = 0;
      while (busy === 1'b1 && cnt < DEPTH + 16) begin
         cnt++;
         step(mi(0, 0, 0, 1, 0, cnt % DEPTH, 0, 0, 0, 0, 0));
         if (bus.host_rvalid !== 1'b0)
            chk("clr_rvalid_dropped", 32'(bus.host_rvalid), 32'd0);
      end
      chk("clr_busy_cycles", cnt, DEPTH);
      for (int a = 0; a < DEPTH; a++)
         hr($sformatf("clr_word%0d", a), a, 32'h0);

      // Reset in CLEAR cycle 10: words >= 10 keep data, acc_start ignored.
      hw(5, 32'h11111111);
      hw(9, 32'h99999999);
      hw(10, 32'hAAAA0010);
      hw(500, 32'h00500500);
      step(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 10; k++) begin
         v = nop();
         if (k == 3) v.st = 1;
         if (k == 4) begin v.wreq = 4'hF; v.addr = 32'(500*4); v.wd = 32'hDEADBEEF; end
         step(v);
      end
      chk("rc_busy_mid", 32'(busy), 32'd1);
      v = nop(); v.rst = 1;
      step(v);
      chk("rc_busy_after_rst", 32'(busy), 32'd0);
      step(nop());
      chk("rc_busy_idle", 32'(busy), 32'd0);
      hr("rc_w0", 0, 32'h0);
      hr("rc_w5", 5, 32'h0);
      hr("rc_w9", 9, 32'h0);
      hr("rc_w10", 10, 32'hAAAA0010);
      hr("rc_w500", 500, 32'h00500500);

      // Randomized traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         v = nop();
         v.rst  = ($urandom_range(0, 799) == 0);
         v.clr  = ($urandom_range(0, 2999) == 0);
         v.st   = ($urandom_range(0, 7) == 0);
         v.fin  = ($urandom_range(0, 11) == 0);
         v.hre  = 1'($urandom_range(0, 1));
         v.hwe  = 1'($urandom_range(0, 1));
         v.ha   = AW'($urandom);
         v.hwd  = $urandom;
         v.rreq = 1'($urandom_range(0, 1));
         v.wreq = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         v.wd   = $urandom;
         if ($urandom_range(0, 9) == 0) v.addr = 32'(DEPTH*4) | $urandom;
         else                           v.addr = 32'($urandom_range(0, DEPTH*4-1));
         step(v);
         chk("rnd_R_data", bus.R_data, m_R);
         chk("rnd_host_rdata", bus.host_rdata, m_H);
         chk("rnd_host_rvalid", 32'(bus.host_rvalid), 32'(m_V));
         chk("rnd_busy", 32'(busy), 32'(m_mode != 0));
         chk("rnd_oor_err", 32'(oor_err), 32'(m_O));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
